csa_multiword_seq: RTL and testbench

- Sequencer that performs WORDS×16-bit add/subtract by time-multiplexing one 16-bit carry-select adder slice.
- Processes one 16-bit word per clock, LSW first, and ripples the carry through an internal register.
- Sits between a requester (start/done handshake) and the shared adder datapath, for wide arithmetic without a wide adder.

---
 rtl/csa_multiword_seq_pkg.sv | 11 +
 rtl/csa_multiword_seq_csa16.sv | 30 +++
 rtl/csa_multiword_seq.sv | 137 +++++++++++++
 tb/tb_csa_multiword_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/csa_multiword_seq_pkg.sv
// rtl/csa_multiword_seq_pkg.sv - shared constants and state encoding for the multiword adder sequencer
package csa_multiword_seq_pkg;

   localparam int WORD_W = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/csa_multiword_seq_csa16.sv
// rtl/csa_multiword_seq_csa16.sv - 16-bit carry-select adder slice, purely combinational
module Carry_Select_Adder_16bits (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [4:0] r0;
   logic [4:0] r1;
   logic       carry;

   // Each 4-bit block precomputes its result for carry-in 0 and 1; the
   // incoming block carry only steers the selection mux.
   always_comb begin
      carry = cin;
      sum   = '0;
      r0    = '0;
      r1    = '0;
      for (int i = 0; i < 4; i++) begin
         r0 = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]};
         r1 = r0 + 5'd1;
         sum[4*i +: 4] = carry ? r1[3:0] : r0[3:0];
         carry         = carry ? r1[4]   : r0[4];
      end
      cout = carry;
   end

endmodule

// File: rtl/csa_multiword_seq.sv
// rtl/csa_multiword_seq.sv - WORDS x 16-bit add/sub sequencer over one shared carry-select slice
import csa_multiword_seq_pkg::*;

module csa_multiword_seq #(
   parameter int WORDS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    op_sub,
   input  logic [WORD_W*WORDS-1:0] a,
   input  logic [WORD_W*WORDS-1:0] b,
   input  logic                    cin,
   output logic                    busy,
   output logic                    done,
   output logic [WORD_W*WORDS-1:0] sum,
   output logic                    cout,
   output logic                    ovf
);

   localparam int W     = WORD_W * WORDS;
   localparam int IDX_W = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             op_sub_q, op_sub_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     work_q, work_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   logic [WORD_W-1:0] slice_a;
   logic [WORD_W-1:0] slice_b;
   logic [WORD_W-1:0] slice_sum;
   logic              slice_cout;
   logic              b_msb_eff;

   // Select the current operand word; subtraction feeds the inverted B word.
   always_comb begin
      slice_a   = a_q[idx_q*WORD_W +: WORD_W];
      slice_b   = op_sub_q ? ~b_q[idx_q*WORD_W +: WORD_W] : b_q[idx_q*WORD_W +: WORD_W];
      b_msb_eff = op_sub_q ? ~b_q[W-1] : b_q[W-1];
   end

   Carry_Select_Adder_16bits u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry_q),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Next-state and datapath: latch operands in IDLE, one word per cycle in RUN;
   // visible results update only on the final word so they are never partial.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      op_sub_d = op_sub_q;
      carry_d  = carry_q;
      work_d   = work_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               op_sub_d = op_sub;
               carry_d  = op_sub ? ~cin : cin;
               idx_d    = '0;
               work_d   = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            work_d[idx_q*WORD_W +: WORD_W] = slice_sum;
            carry_d = slice_cout;
            if (idx_q == LAST_IDX) begin
               sum_d   = work_d;
               cout_d  = slice_cout;
               ovf_d   = (a_q[W-1] == b_msb_eff) && (slice_sum[WORD_W-1] != a_q[W-1]);
               done_d  = 1'b1;
               idx_d   = '0;
               state_d = IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset also discards any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_sub_q <= 1'b0;
         carry_q  <= 1'b0;
         work_q   <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_sub_q <= op_sub_d;
         carry_q  <= carry_d;
         work_q   <= work_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_csa_multiword_seq.sv
// tb/tb_csa_multiword_seq.sv - scoreboard bench for the multiword adder sequencer
module tb_csa_multiword_seq;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         op_sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   exp_t sb[$];

   csa_multiword_seq #(.WORDS(WORDS)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op_sub (op_sub),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .busy   (busy),
      .done   (done),
      .sum    (sum),
      .cout   (cout),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Completion monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sum", sum, e.sum);
            check("cout", W'(cout), W'(e.cout));
            check("ovf", W'(ovf), W'(e.ovf));
            check("latency", W'(cyc), W'(e.due));
         end
      end
   end

   // Called at a negedge with busy=0; start is seen at the next posedge.
   task automatic issue(input logic sub, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic c, input logic [W-1:0] es, input logic ec,
                        input logic eo, input bit push);
      exp_t e;
      if (push) begin
         e.sum  = es;
         e.cout = ec;
         e.ovf  = eo;
         e.due  = cyc + 1 + WORDS;
         sb.push_back(e);
      end
      op_sub = sub;
      a      = av;
      b      = bv;
      cin    = c;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic issue_model(input logic sub, input logic [W-1:0] av,
                              input logic [W-1:0] bv, input logic c);
      logic [W:0]   r;
      logic [W-1:0] be;
      be = sub ? ~bv : bv;
      r  = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, (sub ? ~c : c)};
      issue(sub, av, bv, c, r[W-1:0], r[W],
            (av[W-1] == be[W-1]) && (r[W-1] != av[W-1]), 1'b1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", W'(busy), 0);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 40);
      if (!done) check("done_timeout", W'(done), 1);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", W'(busy), 0);
      check("rst_done", W'(done), 0);
      check("rst_sum", sum, 0);
      check("rst_cout", W'(cout), 0);
      check("rst_ovf", W'(ovf), 0);
      rst = 1'b0;
      @(negedge clk);

      issue(1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b1);
      wait_idle();
      issue(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1);
      wait_idle();
      issue(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
      wait_idle();

      // Handshake: a start during busy is dropped; a start in the done cycle is taken.
      issue(1'b0, 64'h1234, 64'h1111, 1'b0, 64'h2345, 1'b0, 1'b0, 1'b1);
      op_sub = 1'b0;
      a      = 64'hDEAD;
      b      = 64'hBEEF;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      check("hold_sum", sum, 64'h8000_0000_0000_0000);
      check("busy_run", W'(busy), 1);
      wait_done();
      issue(1'b1, 64'd5, 64'd3, 1'b0, 64'd2, 1'b1, 1'b0, 1'b1);
      wait_idle();

      // Reset lands on the second edge after the start edge.
      issue(1'b0, 64'hFFFF_0000_FFFF, 64'h1_0000_0001, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", W'(busy), 0);
      check("abort_sum", sum, 0);
      check("abort_done", W'(done), 0);
      rst = 1'b0;
      issue(1'b0, 64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0, 1'b1);
      wait_idle();

      // Random back-to-back traffic against the arithmetic model.
      for (int i = 0; i < 10; i++) begin
         issue_model(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                     1'($urandom_range(0, 1)));
         wait_idle();
      end

      for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge clk);
      check("sb_empty", W'(sb.size()), 0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
